// File: rtl/dmem_pkg.sv
// Shared types and address decode for the handshaked data-memory responder.
package dmem_pkg;

  localparam int BE_W   = 4;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic [31:0] idx;
    logic        err;
  } dmem_dec_t;

  // Word index from addr[log2(depth)+1:2]; error on misalignment or on any set bit above the array.
  function automatic dmem_dec_t dmem_decode(input logic [63:0] addr, input int depth);
    dmem_dec_t  dec;
    int         aw;
    logic [63:0] mask;
    aw       = $clog2(depth);
    mask     = 64'(depth - 1);
    dec.idx  = 32'((addr >> 2) & mask);
    dec.err  = (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 64'd0);
    return dec;
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// DEPTH x 32-bit storage: synchronous byte-enabled write, asynchronous read.
module dmem_word_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory slave: one request at a time, access after WAIT_CYCLES, held response.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; valid never depends on ready.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_RESP = ST_RESP;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [WORD_W-1:0] cap_wdata;
  logic [BE_W-1:0]   cap_be;

  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              do_access;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;
  dmem_dec_t         dec;

  assign req_ready = (state == S_IDLE) && !reset;
  assign rsp_valid = (state == S_RESP);
  assign dbg_state = state;

  // With no wait states the access happens on the acceptance edge, straight from the request inputs.
  always_comb begin
    acc_we    = cap_we;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    acc_be    = cap_be;
    if (WAIT_CYCLES == 0) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  assign dec       = dmem_decode(64'(acc_addr), DEPTH);
  assign do_access = !reset && ((WAIT_CYCLES == 0) ? (req_valid && req_ready)
                                                    : (state == S_WAIT && cnt == 4'd1));
  assign mem_we    = do_access && acc_we && !dec.err && (acc_be != '0);

  logic unused_idx;
  assign unused_idx = ^dec.idx[31:IDX_W];

  dmem_word_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (dec.idx[IDX_W-1:0]),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      cap_we    <= req_we;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
      cap_be    <= req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (do_access) begin
        rsp_rdata <= (acc_we || dec.err) ? '0 : mem_rdata;
        rsp_err   <= dec.err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: WAIT_CYCLES=2 instance for most traffic, WAIT_CYCLES=0 for throughput.
module tb_dmem_responder;

  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  logic        req_valid_z, req_we_z, rsp_ready_z;
  logic [31:0] req_addr_z, req_wdata_z;
  logic [3:0]  req_be_z;
  logic        req_ready_z, rsp_valid_z, rsp_err_z;
  logic [31:0] rsp_rdata_z;
  logic [1:0]  dbg_state_z;

  logic [32:0] exp_q[$];
  logic [32:0] exp_q_z[$];
  logic [31:0] model_mem [64];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  dmem_responder #(.ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .req_valid(req_valid_z), .req_ready(req_ready_z),
    .req_we(req_we_z), .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_be(req_be_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z),
    .rsp_err(rsp_err_z), .dbg_state(dbg_state_z)
  );

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pushes the model's expected {err, rdata} at acceptance and compares at the response.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold);
    logic        err;
    logic [5:0]  idx;
    logic [32:0] e;
    int          lat;
    err = (addr[1:0] != 2'b00) || (addr[31:8] != 24'd0);
    idx = addr[7:2];
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = (hold == 0);
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("req_ready_before_accept", {32'd0, req_ready}, 33'd1);
    if (err) exp_q.push_back({1'b1, 32'd0});
    else if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      exp_q.push_back(33'd0);
    end else exp_q.push_back({1'b0, model_mem[idx]});
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_we = $urandom_range(0, 1);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 33'(lat), 33'(WC));
    if (exp_q.size() == 0) begin
      chk("queue_empty", 33'd1, 33'd0);
      e = '0;
    end else e = exp_q.pop_front();
    chk("rsp", {rsp_err, rsp_rdata}, e);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
      @(posedge clk); #1;
      chk("bp_hold_rsp", {rsp_err, rsp_rdata}, e);
      chk("bp_hold_valid", {32'd0, rsp_valid}, 33'd1);
      chk("bp_hold_req_ready", {32'd0, req_ready}, 33'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rsp_valid_drop", {32'd0, rsp_valid}, 33'd0);
    chk("req_ready_after_hs", {32'd0, req_ready}, 33'd1);
    req_valid = 1'b0;
    rsp_ready = $urandom_range(0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
    req_valid_z = 1'b0; req_we_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; req_be_z = '0;
    rsp_ready_z = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", {32'd0, req_ready}, 33'd0);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata[30:0]}, 33'd0);
    chk("reset_state", {31'd0, dbg_state}, 33'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_req_ready", {32'd0, req_ready}, 33'd1);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);

    txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    txn(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 0);
    txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 0);

    txn(1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0);
    txn(1'b0, 32'h22, 32'h0, 4'h0, 0);
    txn(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 0);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 0);
    txn(1'b1, 32'hFC, 32'h5A5A0FC0, 4'hF, 0);
    txn(1'b0, 32'hFC, 32'h0, 4'h0, 0);

    txn(1'b0, 32'h10, 32'h0, 4'h0, 5);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);

    txn(1'b1, 32'h4, 32'hCAFE0004, 4'hF, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4; req_wdata = 32'h55; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_rsp", {rsp_err, rsp_rdata}, 33'd0);
    chk("midreset_valid", {32'd0, rsp_valid}, 33'd0);
    chk("midreset_req_ready", {32'd0, req_ready}, 33'd0);
    chk("midreset_state", {31'd0, dbg_state}, 33'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midreset_release_ready", {32'd0, req_ready}, 33'd1);
    txn(1'b0, 32'h4, 32'h0, 4'h0, 0);

    req_valid_z = 1'b1; req_we_z = 1'b1; req_addr_z = 32'h8; req_wdata_z = 32'h12345678;
    req_be_z = 4'hF; rsp_ready_z = 1'b1;
    chk("z_ready_initial", {32'd0, req_ready_z}, 33'd1);
    exp_q_z.push_back(33'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        req_we_z = 1'b0; req_wdata_z = $urandom;
      end
      chk("z_valid_pattern", {32'd0, rsp_valid_z}, {32'd0, (k % 2 == 0)});
      chk("z_ready_pattern", {32'd0, req_ready_z}, {32'd0, (k % 2 == 1)});
      if (rsp_valid_z) begin
        if (exp_q_z.size() == 0) chk("z_queue_empty", 33'd1, 33'd0);
        else chk("z_rsp", {rsp_err_z, rsp_rdata_z}, exp_q_z.pop_front());
      end
      if (k % 2 == 1 && k != 7) exp_q_z.push_back({1'b0, 32'h12345678});
    end
    req_valid_z = 1'b0;
    chk("z_queue_drained", 33'(exp_q_z.size()), 33'd0);
    chk("queue_drained", 33'(exp_q.size()), 33'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
